alu_req_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 8-bit ALU datapath (`main`). It accepts operand/opcode requests over valid/ready handshakes and grants them round-robin. For each granted request it drives the ALU's `in_sel` (persist/load/reset) and one-hot `out_sel` controls through a load–execute sequence. It then returns the captured ALU result to the winning requester with an ID tag.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/rr_grant2.sv | 39 +++
 rtl/alu_req_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_req_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: FSM states, ALU control encodings, op constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    // Default operand/result width of the shared ALU datapath
    localparam int ALU_WIDTH = 8;

    // Sequencer states; encodings are visible on the debug port
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_EXEC = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // ALU input control, {persist, load, reset}
    localparam logic [2:0] IN_PERSIST = 3'b100;
    localparam logic [2:0] IN_LOAD    = 3'b010;
    localparam logic [2:0] IN_RESET   = 3'b001;

    // One-hot ALU operation selects, named by out_sel bit position
    localparam logic [6:0] OP_BIT0 = 7'b0000001;
    localparam logic [6:0] OP_BIT1 = 7'b0000010;
    localparam logic [6:0] OP_BIT2 = 7'b0000100;
    localparam logic [6:0] OP_BIT3 = 7'b0001000;
    localparam logic [6:0] OP_BIT4 = 7'b0010000;
    localparam logic [6:0] OP_BIT5 = 7'b0100000;
    localparam logic [6:0] OP_BIT6 = 7'b1000000;

    // True when exactly one bit of the op select is set
    function automatic logic is_onehot7(input logic [6:0] v);
        return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
    endfunction

endpackage

// File: rtl/rr_grant2.sv
// Two-way grant: round-robin with toggling pointer, or fixed req0 priority when ALU_ARB_FIXED_PRIO_EN is defined.
// Latency: grant is combinational from req; pointer updates on the edge after an accepted grant.
// Backpressure: caller gates req; at most one grant bit is ever set.
module rr_grant2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    // No state needed: req0 always wins a tie
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, advance};

    assign gnt = {req[1] & ~req[0], req[0]};
`else
    logic ptr;

    // Pointer names the preferred requester; flips after every accepted grant
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~ptr;
        end
    end

    // A lone requester always wins; the pointer only breaks ties
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end
`endif

endmodule

// File: rtl/alu_req_arbiter.sv
// Arbitrates two requesters onto the shared ALU and sequences load/execute; optional ALU_ARB_FIXED_PRIO_EN.
// Latency: legal op responds ALU_LAT+2 cycles after acceptance, illegal op 1 cycle; one op per ALU_LAT+3 cycles.
// Backpressure: ready only in IDLE with on=1; no response backpressure, rsp_valid is a one-cycle strobe.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [6:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [6:0]       req1_op,
    output logic [2:0]       alu_in_sel,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [6:0]       alu_out_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       curr_state
);

    typedef struct packed {
        logic             id;
        logic [6:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    // EXEC runs ALU_LAT cycles; the counter reaches zero in the last one
    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t           state;
    req_t             req_q;
    req_t             req_sel;
    logic [3:0]       cnt;
    logic             rsp_vld_q;
    logic             rsp_err_q;
    logic [WIDTH-1:0] rsp_dat_q;
    logic             grant_en;
    logic             accept;
    logic [1:0]       req_vec;
    logic [1:0]       gnt;

    // Grants are only offered from IDLE, while enabled and out of reset
    assign grant_en = (state == ST_IDLE) && on && !rst;
    assign req_vec  = {req1_valid, req0_valid} & {2{grant_en}};

    rr_grant2 u_grant (
        .clk     (clk),
        .rst     (rst),
        .req     (req_vec),
        .advance (accept),
        .gnt     (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    // A grant bit is only set for a valid requester, so any grant is an acceptance
    assign accept     = |gnt;

    // Pick the winning requester's fields for capture
    always_comb begin
        req_sel = '{id: 1'b0, op: req0_op, a: req0_a, b: req0_b};
        if (gnt[1]) begin
            req_sel = '{id: 1'b1, op: req1_op, a: req1_a, b: req1_b};
        end
    end

    // Sequencer: capture request, load ALU, wait ALU_LAT, strobe the response
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            cnt       <= '0;
            rsp_vld_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_dat_q <= '0;
        end else begin
            rsp_vld_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_q <= req_sel;
                        if (is_onehot7(req_sel.op)) begin
                            state <= ST_LOAD;
                        end else begin
                            // Bad opcode never touches the ALU; answer at once with zero data
                            state     <= ST_DONE;
                            rsp_vld_q <= 1'b1;
                            rsp_err_q <= 1'b1;
                            rsp_dat_q <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    cnt   <= CNT_INIT;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (cnt == 4'd0) begin
                        rsp_dat_q <= alu_out;
                        rsp_err_q <= 1'b0;
                        rsp_vld_q <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ALU controls decode from state; reset overrides so the ALU clears in the same cycle
    assign alu_in_sel  = rst ? IN_RESET : ((state == ST_LOAD) ? IN_LOAD : IN_PERSIST);
    assign alu_num1    = rst ? '0 : req_q.a;
    assign alu_num2    = rst ? '0 : req_q.b;
    assign alu_out_sel = (!rst && (state == ST_LOAD || state == ST_EXEC)) ? req_q.op : 7'd0;

    // Response and debug outputs read as idle/zero while reset is held
    assign rsp_valid  = rsp_vld_q & ~rst;
    assign rsp_id     = req_q.id & ~rst;
    assign rsp_err    = rsp_err_q & ~rst;
    assign rsp_data   = rst ? '0 : rsp_dat_q;
    assign curr_state = rst ? ST_IDLE : state;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with an ALU stub and a response scoreboard.
// Latency: checks exact response cycles for ALU_LAT=1.
// Backpressure: drives valid and observes ready; responses are strobes sampled every cycle.
module tb_alu_req_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, on;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [6:0] req0_op, req1_op;
    logic [2:0] alu_in_sel;
    logic [7:0] alu_num1, alu_num2, alu_out;
    logic [6:0] alu_out_sel;
    logic       rsp_valid, rsp_id, rsp_err;
    logic [7:0] rsp_data;
    logic [1:0] curr_state;

    always #5 clk = ~clk;

    alu_req_arbiter #(.WIDTH(8), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst), .on(on),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_in_sel(alu_in_sel), .alu_num1(alu_num1), .alu_num2(alu_num2),
        .alu_out_sel(alu_out_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_data(rsp_data), .curr_state(curr_state)
    );

    // Reference ALU behaviour: op bit 6 add, 5 sub, 4 and, 3 or, 2 xor, 1 not a, 0 pass a
    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [6:0] op);
        case (op)
            7'b1000000: return a + b;
            7'b0100000: return a - b;
            7'b0010000: return a & b;
            7'b0001000: return a | b;
            7'b0000100: return a ^ b;
            7'b0000010: return ~a;
            7'b0000001: return a;
            default:    return 8'h00;
        endcase
    endfunction

    // ALU stub: latches operands on load, result follows the current op select
    logic [7:0] lat_a, lat_b;
    always @(posedge clk) begin
        if (alu_in_sel == 3'b001) begin
            lat_a <= 8'h00;
            lat_b <= 8'h00;
        end else if (alu_in_sel == 3'b010) begin
            lat_a <= alu_num1;
            lat_b <= alu_num2;
        end
    end
    assign alu_out = alu_model(lat_a, lat_b, alu_out_sel);

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic       id;
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   rsp_cnt  = 0;
    int   load_cnt = 0;

    function automatic exp_t make_exp(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [6:0] op);
        exp_t e;
        e.id   = id;
        e.err  = ($countones(op) != 1);
        e.data = e.err ? 8'h00 : alu_model(a, b, op);
        return e;
    endfunction

    // Monitor: mutual exclusion of readys, scoreboard push on acceptance, pop on response
    always @(negedge clk) begin
        exp_t e;
        chk("ready_mutex", {31'b0, req0_ready & req1_ready}, 32'd0);
        if (rst) begin
            sb.delete();
        end else begin
            if (alu_in_sel == 3'b010) load_cnt++;
            if (rsp_valid) begin
                rsp_cnt++;
                chk("rsp_expected", {31'b0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_rsp_id", rsp_id, e.id);
                    chk("sb_rsp_err", rsp_err, e.err);
                    chk("sb_rsp_data", rsp_data, e.data);
                end
            end
            if (req0_valid && req0_ready) sb.push_back(make_exp(1'b0, req0_a, req0_b, req0_op));
            if (req1_valid && req1_ready) sb.push_back(make_exp(1'b1, req1_a, req1_b, req1_op));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case the sequence stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int lbase;
        logic exp_id;

        rst = 1'b1; on = 1'b0;
        req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00; req0_op = 7'd0;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_op = 7'd0;

        // Reset values
        tick(); @(negedge clk);
        chk("rst_state", curr_state, 2'b00);
        chk("rst_in_sel", alu_in_sel, 3'b001);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_num1", alu_num1, 8'h00);
        tick(); rst = 1'b0; @(negedge clk);
        chk("post_rst_in_sel", alu_in_sel, 3'b100);
        chk("post_rst_state", curr_state, 2'b00);
        chk("post_rst_rsp_data", rsp_data, 8'h00);
        chk("post_rst_out_sel", alu_out_sel, 7'd0);
        chk("post_rst_ready0_off", req0_ready, 1'b0);

        // 1: single req0, add
        tick(); on = 1'b1; req0_valid = 1'b1; req0_a = 8'h57; req0_b = 8'h1A; req0_op = 7'b1000000;
        @(negedge clk);
        chk("t1_ready0", req0_ready, 1'b1);
        chk("t1_ready1", req1_ready, 1'b0);
        tick(); req0_valid = 1'b0; @(negedge clk);
        chk("t1_load_in_sel", alu_in_sel, 3'b010);
        chk("t1_load_num1", alu_num1, 8'h57);
        chk("t1_load_num2", alu_num2, 8'h1A);
        chk("t1_load_out_sel", alu_out_sel, 7'b1000000);
        chk("t1_load_state", curr_state, 2'b01);
        tick(); @(negedge clk);
        chk("t1_exec_state", curr_state, 2'b10);
        chk("t1_exec_in_sel", alu_in_sel, 3'b100);
        chk("t1_exec_out_sel", alu_out_sel, 7'b1000000);
        tick(); @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 1'b1);
        chk("t1_rsp_id", rsp_id, 1'b0);
        chk("t1_rsp_err", rsp_err, 1'b0);
        chk("t1_rsp_data", rsp_data, 8'h71);
        tick(); @(negedge clk);
        chk("t1_back_idle", curr_state, 2'b00);
        chk("t1_strobe_one_cycle", rsp_valid, 1'b0);

        // 2 (and fixed-priority variant): both valid held from reset
        tick(); rst = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h33; req0_b = 8'h0F; req0_op = 7'b0100000;
        req1_valid = 1'b1; req1_a = 8'hC3; req1_b = 8'h5A; req1_op = 7'b0000100;
        @(negedge clk);
        chk("t2_rst_ready0", req0_ready, 1'b0);
        chk("t2_rst_ready1", req1_ready, 1'b0);
        tick(); rst = 1'b0; base = rsp_cnt; @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            exp_id = FIXED ? 1'b0 : 1'((i / 4) % 2);
            if (i % 4 == 0) begin
                chk($sformatf("t2_grant0_c%0d", i), req0_ready, !exp_id);
                chk($sformatf("t2_grant1_c%0d", i), req1_ready, exp_id);
            end else begin
                chk($sformatf("t2_nogrant0_c%0d", i), req0_ready, 1'b0);
                chk($sformatf("t2_nogrant1_c%0d", i), req1_ready, 1'b0);
            end
            if (i == 16) chk("t2_rsp_in_16", rsp_cnt - base, 4);
            tick();
            if (i == 19) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("t2_rsp_in_20", rsp_cnt - base, 5);
        chk("t2_idle", curr_state, 2'b00);

        // 3: illegal op from req1
        lbase = load_cnt;
        tick(); req1_valid = 1'b1; req1_a = 8'h12; req1_b = 8'h34; req1_op = 7'b0000011;
        @(negedge clk);
        chk("t3_ready1", req1_ready, 1'b1);
        chk("t3_ready0", req0_ready, 1'b0);
        tick(); req1_valid = 1'b0; @(negedge clk);
        chk("t3_rsp_valid", rsp_valid, 1'b1);
        chk("t3_rsp_id", rsp_id, 1'b1);
        chk("t3_rsp_err", rsp_err, 1'b1);
        chk("t3_rsp_data", rsp_data, 8'h00);
        chk("t3_state_done", curr_state, 2'b11);
        chk("t3_out_sel", alu_out_sel, 7'd0);
        tick(); @(negedge clk);
        chk("t3_idle", curr_state, 2'b00);
        chk("t3_no_load", load_cnt - lbase, 0);

        // 4: reset during EXEC abandons the op
        tick(); req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03; req0_op = 7'b0010000;
        @(negedge clk);
        chk("t4_ready0", req0_ready, 1'b1);
        tick(); req0_valid = 1'b0; @(negedge clk);
        chk("t4_load", curr_state, 2'b01);
        tick(); rst = 1'b1; @(negedge clk);
        chk("t4_rst_in_sel", alu_in_sel, 3'b001);
        chk("t4_rst_rsp_valid", rsp_valid, 1'b0);
        base = rsp_cnt;
        tick(); rst = 1'b0; @(negedge clk);
        chk("t4_after_idle", curr_state, 2'b00);
        chk("t4_after_no_rsp", rsp_valid, 1'b0);
        tick(); @(negedge clk);
        chk("t4_no_rsp_count", rsp_cnt - base, 0);
        tick(); req0_valid = 1'b1; req0_a = 8'h0C; req0_b = 8'h0A; req0_op = 7'b0001000;
        @(negedge clk);
        chk("t4_next_ready0", req0_ready, 1'b1);
        tick(); req0_valid = 1'b0; @(negedge clk);
        tick(); @(negedge clk);
        tick(); @(negedge clk);
        chk("t4_next_rsp_valid", rsp_valid, 1'b1);
        chk("t4_next_rsp_data", rsp_data, 8'h0E);

        // 5: on=0 blocks grants; on dropping mid-op does not stop it
        tick(); on = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h22; req0_b = 8'h11; req0_op = 7'b0100000;
        req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h81; req1_op = 7'b1000000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("t5_off_ready0_%0d", i), req0_ready, 1'b0);
            chk($sformatf("t5_off_ready1_%0d", i), req1_ready, 1'b0);
            tick();
        end
        on = 1'b1;
        exp_id = FIXED ? 1'b0 : 1'b1;
        @(negedge clk);
        chk("t5_on_ready0", req0_ready, !exp_id);
        chk("t5_on_ready1", req1_ready, exp_id);
        tick(); on = 1'b0; @(negedge clk);
        chk("t5_load", curr_state, 2'b01);
        tick(); @(negedge clk);
        chk("t5_exec", curr_state, 2'b10);
        tick(); @(negedge clk);
        chk("t5_rsp_valid", rsp_valid, 1'b1);
        chk("t5_rsp_id", rsp_id, exp_id);
        chk("t5_rsp_data", rsp_data, FIXED ? 8'h11 : 8'h01);
        tick(); req0_valid = 1'b0; req1_valid = 1'b0; @(negedge clk);
        chk("t5_idle", curr_state, 2'b00);
        chk("t5_off_no_ready", req0_ready | req1_ready, 1'b0);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
